// File: rtl/aes_key_expand_pkg.sv
// Shared AES constants for the key schedule: sbox table, rcon seed, xtime reduction.
// Also holds the key-expander state type and small GF(2^8) helpers.
package aes_key_expand_pkg;

    localparam int          AES128_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT     = 8'h01;
    localparam logic [7:0]  XTIME_POLY    = 8'h1b;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ke_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in and round-key-out handshake bundle between the key expander and its neighbours.
interface aes_key_expand_if;

    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, round_key, rk_idx, rk_last, busy
    );

    modport slave (
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, round_key, rk_idx, rk_last, busy
    );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: byte-wise sbox substitution of one 32-bit word, purely combinational.
module aes_sub_word
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox_lookup(word[31:24]), sbox_lookup(word[23:16]),
                  sbox_lookup(word[15:8]),  sbox_lookup(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key, streams round keys 0..10,
// deriving each from the previous one so no full schedule is stored.
//
// state | meaning
// IDLE  | waiting for a cipher key, key_ready high
// EMIT  | presenting round_key[rk_idx], advancing on each rk_ready
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input logic             clk,
    input logic             rst_n,
    aes_key_expand_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ke_state_t    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t;
    logic [31:0]  n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word (rot_w3),
        .sub  (sub_w3)
    );

    // Each new word chains off the one just produced, so all four resolve in one cycle.
    assign t  = sub_w3 ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    key_d   = bus.key_in;
                    idx_d   = '0;
                    rcon_d  = RCON_INIT;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        key_d  = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, never the incoming handshakes.
    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.rk_valid  = (state_q == ST_EMIT);
    assign bus.busy      = (state_q == ST_EMIT);
    assign bus.rk_last   = (state_q == ST_EMIT) && (idx_q == LAST_IDX);
    assign bus.round_key = key_q;
    assign bus.rk_idx    = idx_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a FIPS-197 style word-by-word key schedule
// whose sbox is derived from the GF(2^8) inverse and affine map.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] model_rk [11];
    logic [127:0] got [11];

    int n_got, hold_err, idx_err, last_err, busy_err, ready_err, valid_cycles, first_wait;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents a key and returns just after the clock edge that accepts it.
    task automatic drive_key(input logic [127:0] k);
        int t = 0;
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        while (!bus.key_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 50) begin
            miscompares++;
            $display("FAIL key_accept_timeout key_ready=%b required=1", bus.key_ready);
        end
        @(posedge clk);
    endtask

    // Consumes one 11-key sequence; optionally raises key_valid with nk from index inject_idx on.
    task automatic collect(input int ready_pct, input int inject_idx, input logic [127:0] nk);
        logic         stall = 1'b0;
        logic [127:0] prev_key = '0;
        logic [3:0]   prev_idx = '0;
        int           cyc = 0;
        n_got = 0; hold_err = 0; idx_err = 0; last_err = 0; busy_err = 0;
        ready_err = 0; valid_cycles = 0; first_wait = -1;
        while (n_got < 11 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (inject_idx < 0) bus.key_valid = 1'b0;
            bus.rk_ready = 1'b0;
            if (bus.rk_valid) begin
                if (first_wait < 0) first_wait = cyc - 1;
                valid_cycles++;
                if (stall && (bus.round_key !== prev_key || bus.rk_idx !== prev_idx)) hold_err++;
                if (bus.key_ready !== 1'b0) ready_err++;
                if (bus.busy !== 1'b1) busy_err++;
                if (bus.rk_last !== (n_got == 10)) last_err++;
                if ($urandom_range(99) < ready_pct) begin
                    bus.rk_ready = 1'b1;
                    got[n_got] = bus.round_key;
                    if (bus.rk_idx !== n_got[3:0]) idx_err++;
                    if (inject_idx >= 0 && n_got >= inject_idx) begin
                        bus.key_valid = 1'b1;
                        bus.key_in    = nk;
                    end
                    n_got++;
                    stall = 1'b0;
                end else begin
                    stall    = 1'b1;
                    prev_key = bus.round_key;
                    prev_idx = bus.rk_idx;
                end
            end
        end
    endtask

    // Compares a collected sequence and its protocol error counters against the model.
    task automatic check_seq(input string tag);
        vectors++;
        if (n_got !== 11) begin
            miscompares++;
            $display("FAIL %s_count got=%0d required=11", tag, n_got);
        end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (got[i] !== model_rk[i]) begin
                miscompares++;
                $display("FAIL %s_rk%0d got=%h required=%h", tag, i, got[i], model_rk[i]);
            end
        end
        vectors++;
        if ({hold_err, idx_err, last_err, busy_err, ready_err} !== '0) begin
            miscompares++;
            $display("FAIL %s_protocol hold=%0d idx=%0d last=%0d busy=%0d kready=%0d required=all 0",
                     tag, hold_err, idx_err, last_err, busy_err, ready_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_in    = rand128();
        bus.rk_ready  = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.key_ready, bus.rk_valid, bus.rk_last, bus.busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b required=1000",
                     {bus.key_ready, bus.rk_valid, bus.rk_last, bus.busy});
        end
        vectors++;
        if (bus.round_key !== 128'h0 || bus.rk_idx !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data round_key=%h rk_idx=%0d required=0/0", bus.round_key, bus.rk_idx);
        end
        bus.key_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept rk_valid=%b key_ready=%b required=0/1", bus.rk_valid, bus.key_ready);
        end
    endtask

    task automatic test_fips_a1();
        expand(KEY_A1);
        drive_key(KEY_A1);
        collect(100, -1, '0);
        check_seq("a1");
        vectors++;
        if (got[0] !== KEY_A1 || got[1] !== A1_RK1 || got[2] !== A1_RK2 || got[10] !== A1_RK10) begin
            miscompares++;
            $display("FAIL a1_golden rk1=%h rk2=%h rk10=%h required=%h %h %h",
                     got[1], got[2], got[10], A1_RK1, A1_RK2, A1_RK10);
        end
        vectors++;
        if (valid_cycles !== 11 || first_wait !== 0) begin
            miscompares++;
            $display("FAIL a1_timing valid_cycles=%0d latency=%0d required=11/0", valid_cycles, first_wait);
        end
        @(negedge clk);
        vectors++;
        if (bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL a1_end rk_valid=%b key_ready=%b required=0/1", bus.rk_valid, bus.key_ready);
        end
    endtask

    task automatic test_backpressure();
        expand(KEY_A1);
        drive_key(KEY_A1);
        collect(50, -1, '0);
        check_seq("bp_a1");
        for (int k = 0; k < 3; k++) begin
            logic [127:0] key = rand128();
            expand(key);
            drive_key(key);
            collect(int'($urandom_range(90, 25)), -1, '0);
            check_seq("bp_rand");
        end
    endtask

    task automatic test_key_during_emit();
        int t = 0;
        expand(KEY_A1);
        drive_key(KEY_A1);
        collect(100, 4, KEY_C1);
        check_seq("emit_first");
        @(negedge clk);
        while (!bus.key_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        expand(KEY_C1);
        collect(100, -1, '0);
        check_seq("emit_second");
        vectors++;
        if (got[10] !== C1_RK10 || first_wait !== 0 || t !== 0) begin
            miscompares++;
            $display("FAIL emit_second_golden rk10=%h wait=%0d idle_wait=%0d required=%h/0/0",
                     got[10], first_wait, t, C1_RK10);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int stray = 0;
        expand(KEY_A1);
        drive_key(KEY_A1);
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        @(negedge clk);
        while (!(bus.rk_valid && bus.rk_idx == 4'd6) && t < 40) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({bus.rk_valid, bus.key_ready, bus.rk_last, bus.busy} !== 4'b0100 ||
            bus.rk_idx !== 4'h0 || bus.round_key !== 128'h0) begin
            miscompares++;
            $display("FAIL mid_reset valid/ready/last/busy=%b idx=%0d rk=%h required=0100/0/0",
                     {bus.rk_valid, bus.key_ready, bus.rk_last, bus.busy}, bus.rk_idx, bus.round_key);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.rk_valid) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_stray rk_valid_cycles=%0d required=0", stray);
        end
        drive_key(KEY_A1);
        collect(100, -1, '0);
        check_seq("mid_reset_after");
        vectors++;
        if (got[1] !== A1_RK1) begin
            miscompares++;
            $display("FAIL mid_reset_rk1 got=%h required=%h", got[1], A1_RK1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            logic [127:0] ka = rand128();
            logic [127:0] kb = rand128();
            int t = 0;
            int pct = (k == 0) ? 100 : 60;
            expand(ka);
            drive_key(ka);
            collect(pct, 0, kb);
            check_seq("b2b_first");
            @(negedge clk);
            while (!bus.key_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            expand(kb);
            collect(pct, -1, '0);
            check_seq("b2b_second");
            vectors++;
            if (first_wait !== 0 || t !== 0) begin
                miscompares++;
                $display("FAIL b2b_idle_gap idle_wait=%0d latency=%0d required=0/0", t, first_wait);
            end
        end
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_ready  = 1'b0;
        build_sbox();
        test_reset();
        test_fips_a1();
        test_backpressure();
        test_key_during_emit();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. It sits directly upstream of AES_core and supplies its round_key input.
- Accepts one 128-bit cipher key through a valid/ready handshake.
- Streams round keys 0..10 in order, one per accepted transfer, with downstream backpressure.
- Computes one round key per cycle from the previous one. No 176-byte key store.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted (AES-128 only). Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- key_valid  input  1  cipher key on key_in is valid
- key_ready  output  1  block can accept a new key
- key_in  input  128  cipher key; w0 = [127:96], w1 = [95:64], w2 = [63:32], w3 = [31:0]; byte 0 = [127:120]
- rk_valid  output  1  round_key / rk_idx are valid
- rk_ready  input  1  consumer accepts the current round key
- round_key  output  128  current round key, same byte order as key_in
- rk_idx  output  4  index of the current round key, 0..10
- rk_last  output  1  high with rk_valid when rk_idx == NUM_ROUNDS
- busy  output  1  high in EMIT

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE, key_ready = 1, rk_valid = 0, round_key = 0, rk_idx = 0, rk_last = 0, busy = 0.
  - Reset takes effect mid-expansion; the in-progress sequence is abandoned with no further rk_valid.
- State IDLE:
  - key_ready = 1, rk_valid = 0.
  - On key_valid & key_ready: round_key <= key_in, rk_idx <= 0, rcon <= 8'h01, go to EMIT.
  - First rk_valid appears the cycle after key acceptance (latency 1).
- State EMIT:
  - key_ready = 0; key_valid is ignored and key_in is not sampled.
  - rk_valid = 1. round_key and rk_idx are held stable while rk_ready = 0.
  - On rk_valid & rk_ready with rk_idx < NUM_ROUNDS: round_key <= next_key(round_key, rcon), rk_idx <= rk_idx + 1, rcon <= xtime(rcon). Stay in EMIT.
  - On rk_valid & rk_ready with rk_idx == NUM_ROUNDS: go to IDLE; rk_valid drops next cycle, key_ready rises next cycle.
  - With rk_ready tied high: 11 consecutive valid cycles, indices 0..10, then IDLE for at least 1 cycle before the next key is accepted.
- next_key computation:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord(w) = {w[23:0], w[31:24]}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - xtime(x) = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00). This is 8-bit arithmetic with no overflow bit.
- rk_idx does not wrap past NUM_ROUNDS; the transition back to IDLE resets it on the next key acceptance.
- Simultaneous events:
  - Final handshake and a new key_valid in the same cycle: the key is not accepted (key_ready is 0 in EMIT).
  - The key is accepted on the first IDLE cycle in which key_valid is high.
- All outputs are registered. There is no combinational path from rk_ready or key_valid to any output.

Decomposition:
- Shared constant package:
  - existing sbox table (the same table used by AES_core subBytes);
  - RCON_INIT = 8'h01, the xtime reduction constant 8'h1b, and AES128_ROUNDS = 10.
- Sub-module aes_sub_word:
  - purely combinational, 32 -> 32;
  - four sbox lookups from the package table;
  - instanced once, on RotWord(w3).

Test Plan:
- FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready = 1 ->
  - idx0 = key;
  - idx1 = a0fafe1788542cb123a339392a6c7605;
  - idx2 = f2c295f27a96b9435935807a7359f67f;
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1;
  - 11 valid cycles total.
- Backpressure: same key, rk_ready randomly low ~50% of cycles ->
  - identical 11-key sequence;
  - round_key and rk_idx unchanged on every cycle where rk_valid & !rk_ready.
- Key during EMIT: assert key_valid with key 000102030405060708090a0b0c0d0e0f at idx 4 of the first sequence ->
  - first sequence completes unchanged;
  - second key accepted only after IDLE;
  - its idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-operation: pull rst_n low for 1 cycle at idx 6 ->
  - next cycle rk_valid = 0, key_ready = 1, rk_idx = 0, round_key = 0;
  - new A.1 key then gives the correct idx1.
- Back-to-back keys: key_valid held high with two keys ->
  - key_ready high exactly one cycle between sequences;
  - both sequences match the golden model;
  - rcon restarts at 01 for the second key.
- Reset values: hold rst_n low for 3 cycles with key_valid = 1 -> no key accepted; every output at its listed reset value.
